// File: rtl/div_seq_ctrl_if.sv
// Operand, control and result bundle between the execute stage and the
// sequential divider. The stage drives the master side; the divider is the slave.
interface div_seq_ctrl_if #(
  parameter int DATA_W = 32
);
  logic              start;
  logic              signed_div;
  logic [DATA_W-1:0] dividend;
  logic [DATA_W-1:0] divisor;
  logic              cancel;
  logic              stall;
  logic              busy;
  logic              result_valid;
  logic              div_by_zero;
  logic [DATA_W-1:0] quotient;
  logic [DATA_W-1:0] remainder;
  logic              whilo;

  modport master (
    output start, signed_div, dividend, divisor, cancel,
    input  stall, busy, result_valid, div_by_zero, quotient, remainder, whilo
  );

  modport slave (
    input  start, signed_div, dividend, divisor, cancel,
    output stall, busy, result_valid, div_by_zero, quotient, remainder, whilo
  );
endinterface

// File: rtl/div_seq_ctrl.sv
// Multi-cycle DIV/DIVU sequencer for the execute stage. It is a radix-2
// restoring divider that produces one quotient bit per cycle. The pipeline is
// held for the whole operation. The result is then presented for one cycle,
// together with the HI/LO write strobe.
module div_seq_ctrl #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic          clk,
  input  logic          rst,
  div_seq_ctrl_if.slave bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]        state_q,     state_d;
  logic [CNT_W-1:0]  cnt_q,       cnt_d;
  logic [DATA_W-1:0] quo_q,       quo_d;        // working quotient / shifted dividend
  logic [DATA_W-1:0] rem_q,       rem_d;        // partial remainder
  logic [DATA_W-1:0] dvs_q,       dvs_d;        // divisor magnitude
  logic              q_neg_q,     q_neg_d;
  logic              r_neg_q,     r_neg_d;
  logic [DATA_W-1:0] quotient_q,  quotient_d;
  logic [DATA_W-1:0] remainder_q, remainder_d;
  logic              dbz_q,       dbz_d;

  logic              accept;
  logic [DATA_W-1:0] dividend_abs;
  logic [DATA_W-1:0] divisor_abs;
  logic [DATA_W:0]   rem_shift;
  logic [DATA_W:0]   rem_diff;
  logic [DATA_W-1:0] quo_shift;
  logic [DATA_W-1:0] rem_step;
  logic [DATA_W-1:0] quo_step;

  // A new divide is taken only from IDLE, and only if it is not flushed.
  assign accept = (state_q == ST_IDLE) && bus.start && !bus.cancel;

  // Only DIV works on magnitudes. Negating 0x80000000 gives 0x80000000 back,
  // and that is the correct unsigned magnitude.
  assign dividend_abs = (bus.signed_div && bus.dividend[DATA_W-1]) ? -bus.dividend : bus.dividend;
  assign divisor_abs  = (bus.signed_div && bus.divisor[DATA_W-1])  ? -bus.divisor  : bus.divisor;

  // One restoring step. The shifted remainder needs DATA_W+1 bits, because an
  // unsigned divisor can be as large as 2^DATA_W - 1.
  assign rem_shift = {rem_q, quo_q[DATA_W-1]};
  assign quo_shift = {quo_q[DATA_W-2:0], 1'b0};
  assign rem_diff  = rem_shift - {1'b0, dvs_q};

  // Trial subtraction: keep the difference and set the quotient bit when the shifted remainder covers the divisor
  always_comb begin
    if (rem_shift >= {1'b0, dvs_q}) begin
      rem_step = rem_diff[DATA_W-1:0];
      quo_step = quo_shift | DATA_W'(1);
    end else begin
      rem_step = rem_shift[DATA_W-1:0];
      quo_step = quo_shift;
    end
  end

  // Next-state logic: accept, iterate, fix up signs, and let cancel override everything
  always_comb begin
    // NOTE: every _d is first defaulted to its _q so that no path leaves a
    // variable unassigned; an unassigned path would infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    quo_d       = quo_q;
    rem_d       = rem_q;
    dvs_d       = dvs_q;
    q_neg_d     = q_neg_q;
    r_neg_d     = r_neg_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (bus.divisor == '0) begin
            state_d     = ST_DONE;
            quotient_d  = '1;
            remainder_d = bus.dividend;
            dbz_d       = 1'b1;
          end else begin
            state_d = ST_BUSY;
            quo_d   = dividend_abs;
            dvs_d   = divisor_abs;
            rem_d   = '0;
            cnt_d   = CNT_W'(DATA_W);
            q_neg_d = bus.signed_div && (bus.dividend[DATA_W-1] ^ bus.divisor[DATA_W-1]);
            r_neg_d = bus.signed_div && bus.dividend[DATA_W-1];
            dbz_d   = 1'b0;
          end
        end
      end
      ST_BUSY: begin
        quo_d = quo_step;
        rem_d = rem_step;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d     = ST_DONE;
          quotient_d  = q_neg_q ? -quo_step : quo_step;
          remainder_d = r_neg_q ? -rem_step : rem_step;
        end
      end
      ST_DONE: begin
        // start is ignored here: the same instruction is still in EX.
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // A flush abandons the operation and leaves the visible result untouched.
    if (bus.cancel) begin
      state_d     = ST_IDLE;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      dbz_d       = dbz_q;
    end
  end

  // State registers with synchronous reset; rst has priority over cancel and start
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values and no update order is implied.
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      quo_q       <= '0;
      rem_q       <= '0;
      dvs_q       <= '0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      quo_q       <= quo_d;
      rem_q       <= rem_d;
      dvs_q       <= dvs_d;
      q_neg_q     <= q_neg_d;
      r_neg_q     <= r_neg_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  // stall is low in DONE so that the instruction can advance.
  assign bus.stall        = accept || (state_q == ST_BUSY);
  assign bus.busy         = (state_q != ST_IDLE);
  assign bus.result_valid = (state_q == ST_DONE) && !bus.cancel;
  assign bus.whilo        = bus.result_valid;
  assign bus.div_by_zero  = bus.result_valid && dbz_q;
  assign bus.quotient     = quotient_q;
  assign bus.remainder    = remainder_q;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Scoreboard bench for div_seq_ctrl. Each directed divide pushes its
// hand-computed result into a queue. A monitor pops an entry and compares it
// whenever the result strobe fires.
module tb_div_seq_ctrl;

  typedef struct packed {
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  div_seq_ctrl_if #(.DATA_W(32)) bus ();

  div_seq_ctrl #(.DATA_W(32), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every result strobe must match the oldest expected entry
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.result_valid || bus.whilo)
        check("whilo_eq_valid", 32'(bus.whilo), 32'(bus.result_valid));
      if (bus.div_by_zero && !bus.result_valid)
        check("dbz_outside_done", 32'(bus.div_by_zero), 32'd0);
      if (bus.result_valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_result: got q=0x%08h r=0x%08h, expected no result",
                   bus.quotient, bus.remainder);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("sb_quotient",  bus.quotient,  e.q);
          check("sb_remainder", bus.remainder, e.r);
          check("sb_dbz",       32'(bus.div_by_zero), 32'(e.dbz));
        end
      end
    end
  end

  // One divide: push the expectation, hold start until DONE, then check latency, stall length and hold
  task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eq, input logic [31:0] er, input logic edbz,
                         input int exp_lat, input int exp_stall, input logic hold);
    int lat;
    int st;
    exp_q.push_back('{q: eq, r: er, dbz: edbz});
    @(posedge clk); #1;
    bus.start      = 1'b1;
    bus.signed_div = sgn;
    bus.dividend   = a;
    bus.divisor    = b;
    lat = -1;
    st  = 0;
    for (int i = 0; i < 100 && lat < 0; i++) begin
      @(negedge clk);
      if (bus.stall) st++;
      if (bus.result_valid) lat = i;
    end
    check("latency", 32'(lat), 32'(exp_lat));
    check("stall_cycles", 32'(st), 32'(exp_stall));
    if (hold) begin
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    @(negedge clk);
    check("valid_drop", 32'(bus.result_valid), 32'd0);
    check("q_hold", bus.quotient, eq);
    check("r_hold", bus.remainder, er);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.start      = 1'b0;
    bus.signed_div = 1'b0;
    bus.dividend   = '0;
    bus.divisor    = '0;
    bus.cancel     = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_busy",      32'(bus.busy),         32'd0);
    check("rst_stall",     32'(bus.stall),        32'd0);
    check("rst_valid",     32'(bus.result_valid), 32'd0);
    check("rst_whilo",     32'(bus.whilo),        32'd0);
    check("rst_dbz",       32'(bus.div_by_zero),  32'd0);
    check("rst_quotient",  bus.quotient,          32'd0);
    check("rst_remainder", bus.remainder,         32'd0);

    // Directed vectors with hand-computed results.
    run_div(1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 33, 33, 1'b0);
    run_div(1'b1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF,   1'b0, 33, 33, 1'b0);
    run_div(1'b1, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1,          1'b0, 33, 33, 1'b0);
    run_div(1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          1'b0, 33, 33, 1'b0);
    run_div(1'b0, 32'hFFFFFFFF,   32'h80000000,   32'd1,          32'h7FFFFFFF,   1'b0, 33, 33, 1'b0);
    run_div(1'b0, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0,          1'b0, 33, 33, 1'b0);
    run_div(1'b0, 32'h00001234,   32'd0,          32'hFFFFFFFF,   32'h00001234,   1'b1, 1,  1,  1'b0);
    run_div(1'b1, 32'hFFFFFF00,   32'd0,          32'hFFFFFFFF,   32'hFFFFFF00,   1'b1, 1,  1,  1'b0);

    // Cancel in BUSY at T+10: idle at T+11 with no result, then restart at T+12.
    @(posedge clk); #1;
    bus.start = 1'b1; bus.signed_div = 1'b0; bus.dividend = 32'd50; bus.divisor = 32'd5;
    repeat (10) @(posedge clk);
    #1 bus.cancel = 1'b1; bus.start = 1'b0;
    @(posedge clk); #1 bus.cancel = 1'b0;
    @(negedge clk);
    check("cancel_busy_idle",  32'(bus.busy),  32'd0);
    check("cancel_busy_stall", 32'(bus.stall), 32'd0);
    run_div(1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 33, 33, 1'b0);

    // cancel and start together in IDLE: cancel wins, no stall, nothing started.
    @(posedge clk); #1;
    bus.start = 1'b1; bus.cancel = 1'b1; bus.dividend = 32'd8; bus.divisor = 32'd2;
    @(negedge clk);
    check("cancel_start_stall", 32'(bus.stall), 32'd0);
    @(posedge clk); #1 bus.start = 1'b0; bus.cancel = 1'b0;
    @(negedge clk);
    check("cancel_start_busy", 32'(bus.busy), 32'd0);

    // start held through DONE: exactly one strobe; a second one would be unexpected.
    run_div(1'b0, 32'd20, 32'd4, 32'd5, 32'd0, 1'b0, 33, 33, 1'b1);
    repeat (40) @(negedge clk);
    check("held_start_idle", 32'(bus.busy), 32'd0);

    // cancel in DONE suppresses the strobe.
    @(posedge clk); #1;
    bus.start = 1'b1; bus.dividend = 32'd21; bus.divisor = 32'd4;
    repeat (33) @(posedge clk);
    #1 bus.cancel = 1'b1; bus.start = 1'b0;
    @(negedge clk);
    check("cancel_done_busy",  32'(bus.busy),         32'd1);
    check("cancel_done_valid", 32'(bus.result_valid), 32'd0);
    check("cancel_done_whilo", 32'(bus.whilo),        32'd0);
    @(posedge clk); #1 bus.cancel = 1'b0;
    @(negedge clk);
    check("cancel_done_idle", 32'(bus.busy), 32'd0);

    // rst at T+5 mid-BUSY: reset values at T+6.
    @(posedge clk); #1;
    bus.start = 1'b1; bus.dividend = 32'd100; bus.divisor = 32'd7;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1; bus.start = 1'b0;
    @(negedge clk);
    check("pre_rst_busy", 32'(bus.busy), 32'd1);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("mid_rst_busy",      32'(bus.busy),         32'd0);
    check("mid_rst_stall",     32'(bus.stall),        32'd0);
    check("mid_rst_valid",     32'(bus.result_valid), 32'd0);
    check("mid_rst_quotient",  bus.quotient,          32'd0);
    check("mid_rst_remainder", bus.remainder,         32'd0);
    repeat (40) @(negedge clk);
    check("mid_rst_no_result", 32'(bus.busy), 32'd0);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/div_seq_ctrl.md
Name: div_seq_ctrl

Overview:
- Multi-cycle sequencer for DIV/DIVU in the execute stage: radix-2 restoring divider, one quotient bit per cycle.
- Holds the pipeline via stall for the duration, then presents the quotient (LO) and remainder (HI) with a one-cycle HI/LO write strobe.
- Sits beside the execute ALU. It consumes the same src1/src2 operands and drives the stage's arith_stall and HI/LO write path.

Parameters:
- DATA_W, 32, operand/result width. Only 32 is supported by the pipeline.
- CNT_W, 6, iteration counter width; must hold DATA_W.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  divide requested by the instruction currently in EX (level)
- signed_div  in  1  1 = DIV, 0 = DIVU; sampled with start
- dividend  in  DATA_W  src1
- divisor  in  DATA_W  src2
- cancel  in  1  flush of the EX instruction; aborts any operation
- stall  out  1  hold the pipeline (to arith_stall)
- busy  out  1  state != IDLE
- result_valid  out  1  result is present this cycle
- div_by_zero  out  1  qualifies result_valid
- quotient  out  DATA_W  LO value
- remainder  out  DATA_W  HI value
- whilo  out  1  HI/LO write enable; equals result_valid

Behaviour:
- Reset values:
  - State is IDLE.
  - Counter, quotient, remainder, result_valid and div_by_zero are 0.
  - stall, busy and whilo are 0.
- States: IDLE, BUSY, DONE.
- IDLE, start=1, cancel=0, divisor!=0:
  - Latch abs(dividend) and abs(divisor); abs applies only when signed_div=1.
  - Latch q_neg = signed_div & (dividend[31]^divisor[31]) and r_neg = signed_div & dividend[31].
  - Clear the partial remainder; load counter = DATA_W; go to BUSY.
- IDLE, start=1, cancel=0, divisor==0: go directly to DONE with quotient=32'hFFFFFFFF, remainder=dividend and div_by_zero=1.
- BUSY, each cycle:
  - Shift {rem,quo} left by 1.
  - If the shifted rem >= divisor magnitude, subtract it and set quo[0]=1.
  - Decrement the counter. When it reaches 0, apply the signs and go to DONE.
- Sign fix-up:
  - quotient = q_neg ? -quo : quo
  - remainder = r_neg ? -rem : rem
  - Two's-complement wrap: 0x80000000 / -1 yields quotient 0x80000000, remainder 0 with no exception.
- DONE:
  - result_valid = whilo = 1 for exactly one cycle, then return to IDLE.
  - start is ignored here, because the same instruction is still in EX.
- stall = (state==IDLE & start & ~cancel) | (state==BUSY). stall is 0 in DONE so the instruction advances.
- Latency, start accepted in cycle T:
  - BUSY occupies T+1..T+32.
  - DONE is at T+33.
  - stall is high for T..T+32 (33 cycles).
  - Divide-by-zero: DONE at T+1, stall high only in T.
- quotient and remainder are registered and hold their value after DONE until the next accepted start.
- result_valid and div_by_zero drop to 0 outside DONE.
- cancel:
  - Takes effect in any state: the next state is IDLE, no result_valid/whilo, and quotient/remainder are not updated.
  - cancel and start in the same IDLE cycle: cancel wins and stall = 0.
  - cancel in DONE suppresses result_valid and whilo that cycle.
- rst mid-operation: returns to IDLE with all reset values on the next edge. rst has priority over cancel and start.
- Back-to-back divides: the second start is seen in IDLE the cycle after DONE and is accepted normally.

Test Plan:
- DIVU, 100 / 7, start at T:
  - stall high T..T+32.
  - At T+33: result_valid=whilo=1, quotient=14, remainder=2.
  - At T+34: result_valid=0 and the values are held.
- DIV, -7 / 2 (0xFFFFFFF9 / 2): quotient 0xFFFFFFFD, remainder 0xFFFFFFFF.
- DIV, 7 / -2: quotient 0xFFFFFFFD, remainder 1.
- DIV, 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0, div_by_zero=0.
- Divisor 0, dividend 0x1234:
  - stall high one cycle.
  - Next cycle: result_valid=1, div_by_zero=1, quotient=0xFFFFFFFF, remainder=0x1234.
- DIVU 50 / 5 started, cancel at T+10:
  - State is IDLE at T+11, with no result_valid ever.
  - Restart at T+12 with 9 / 3: quotient 3, remainder 0 at T+45.
- start held high through DONE: exactly one result_valid pulse.
- rst asserted at T+5 mid-BUSY: all outputs return to reset values at T+6 and busy=0.
